// File: rtl/systolic_mm_nxn_if.sv
// Handshake/bus bundle for systolic_mm_nxn.
//   Input side : in_valid/in_ready/in_last plus one beat (a_col = column k of A,
//                b_row = row k of B, element i at [i*DATA_W +: DATA_W]).
//   Output side: c_valid/c_ready plus one result element c_data = C[c_row][c_col].
//   master : producer of beats / consumer of results (testbench side)
//   slave  : the multiplier
interface systolic_mm_nxn_if #(
    parameter int N      = 2,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
);
    localparam int RC_W = (N > 1) ? $clog2(N) : 1;

    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [N*DATA_W-1:0] a_col;
    logic [N*DATA_W-1:0] b_row;
    logic                c_valid;
    logic                c_ready;
    logic [ACC_W-1:0]    c_data;
    logic [RC_W-1:0]     c_row;
    logic [RC_W-1:0]     c_col;

    modport master (
        output in_valid, in_last, a_col, b_row, c_ready,
        input  in_ready, c_valid, c_data, c_row, c_col
    );
    modport slave (
        input  in_valid, in_last, a_col, b_row, c_ready,
        output in_ready, c_valid, c_data, c_row, c_col
    );
endinterface

// File: rtl/systolic_mm_nxn.sv
// Output-stationary NxN systolic matrix multiplier, C = A x B over K streamed beats.
// Row i of A and column j of B are skewed by i / j cycles, then flow right/down
// through an NxN grid of multiply-accumulate PEs. After the beat flagged in_last
// the grid drains for 2N-1 cycles and C is emitted row-major on c_*.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : systolic_mm_nxn_if.slave (input beats, result stream)
//   busy     : job in progress (not IDLE)
//   dbg_c    : only with SYSMM_DBG_C_EN defined; all accumulators,
//              PE(i,j) at [(i*N+j)*ACC_W +: ACC_W]

// One grid cell: accumulates a*b when both operands are valid and forwards
// the operands (with their valid bits) one cycle later.
module systolic_mm_nxn_pe #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic              a_v_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              b_v_i,
    output logic [DATA_W-1:0] a_o,
    output logic              a_v_o,
    output logic [DATA_W-1:0] b_o,
    output logic              b_v_o,
    output logic [ACC_W-1:0]  acc_o
);
    logic [DATA_W-1:0] a_q, b_q;
    logic              a_v_q, b_v_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  a_ext, b_ext;

    // The low ACC_W bits of a*b only depend on the low ACC_W bits of each operand.
    assign a_ext = ACC_W'(a_i);
    assign b_ext = ACC_W'(b_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            a_v_q <= 1'b0;
            b_v_q <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            a_v_q <= a_v_i;
            b_v_q <= b_v_i;
            if (clr_i)
                acc_q <= '0;
            else if (a_v_i && b_v_i)
                acc_q <= acc_q + a_ext * b_ext;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign a_v_o = a_v_q;
    assign b_v_o = b_v_q;
    assign acc_o = acc_q;
endmodule

module systolic_mm_nxn #(
    parameter int N      = 2,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic clk,
    input  logic rst,
    systolic_mm_nxn_if.slave bus,
    output logic busy
`ifdef SYSMM_DBG_C_EN
    ,
    output logic [N*N*ACC_W-1:0] dbg_c
`endif
);
    localparam int RC_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(2 * N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready_q, busy_q, c_valid_q;
    logic [ACC_W-1:0]  c_data_q;
    logic [RC_W-1:0]   c_row_q, c_col_q;

    logic              accept, out_hs, last_elem, clr_acc;
    logic [RC_W-1:0]   nxt_row, nxt_col;
    logic [ACC_W-1:0]  nxt_data;

    // ---------------- input skew ----------------
    logic [DATA_W-1:0] a_sk [N];
    logic [DATA_W-1:0] b_sk [N];
    logic              sk_v [N];

    assign accept = bus.in_valid & in_ready_q;

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_nodly
            assign a_sk[i] = bus.a_col[i*DATA_W +: DATA_W];
            assign b_sk[i] = bus.b_row[i*DATA_W +: DATA_W];
            assign sk_v[i] = accept;
        end else begin : g_dly
            // A row i and B column i see the same delay, so one valid chain
            // tags both; bubbles simply travel through as zero valid bits.
            logic [i-1:0][DATA_W-1:0] a_q, b_q;
            logic [i-1:0]             vld_pipe;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q      <= '0;
                    b_q      <= '0;
                    vld_pipe <= '0;
                end else begin
                    a_q[0]      <= bus.a_col[i*DATA_W +: DATA_W];
                    b_q[0]      <= bus.b_row[i*DATA_W +: DATA_W];
                    vld_pipe[0] <= accept;
                    for (int d = 1; d < i; d++) begin
                        a_q[d]      <= a_q[d-1];
                        b_q[d]      <= b_q[d-1];
                        vld_pipe[d] <= vld_pipe[d-1];
                    end
                end
            end
            assign a_sk[i] = a_q[i-1];
            assign b_sk[i] = b_q[i-1];
            assign sk_v[i] = vld_pipe[i-1];
        end
    end

    // ---------------- PE grid ----------------
    logic [DATA_W-1:0] a_h  [N][N+1];
    logic              av_h [N][N+1];
    logic [DATA_W-1:0] b_vt [N+1][N];
    logic              bv_vt[N+1][N];
    logic [ACC_W-1:0]  acc_u[N*N];
    logic [N*N-1:0][ACC_W-1:0] acc_w;

    for (genvar i = 0; i < N; i++) begin : g_row
        assign a_h[i][0]   = a_sk[i];
        assign av_h[i][0]  = sk_v[i];
        assign b_vt[0][i]  = b_sk[i];
        assign bv_vt[0][i] = sk_v[i];
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_mm_nxn_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr_i (clr_acc),
                .a_i   (a_h[i][j]),
                .a_v_i (av_h[i][j]),
                .b_i   (b_vt[i][j]),
                .b_v_i (bv_vt[i][j]),
                .a_o   (a_h[i][j+1]),
                .a_v_o (av_h[i][j+1]),
                .b_o   (b_vt[i+1][j]),
                .b_v_o (bv_vt[i+1][j]),
                .acc_o (acc_u[i*N+j])
            );
            assign acc_w[i*N+j] = acc_u[i*N+j];
        end
    end

    // Operands leaving the right/bottom edge of the grid go nowhere.
    logic unused_edges;
    always_comb begin
        unused_edges = 1'b0;
        for (int k = 0; k < N; k++)
            unused_edges = unused_edges ^ (^a_h[k][N]) ^ av_h[k][N]
                                        ^ (^b_vt[N][k]) ^ bv_vt[N][k];
    end

    // ---------------- result sequencing ----------------
    assign out_hs    = c_valid_q & bus.c_ready;
    assign last_elem = (c_row_q == RC_W'(N - 1)) && (c_col_q == RC_W'(N - 1));
    // Clearing on the final handshake lets the next job start from zero.
    assign clr_acc   = (state_q == S_OUT) && out_hs && last_elem;

    always_comb begin
        nxt_row = c_row_q;
        nxt_col = c_col_q + 1'b1;
        if (c_col_q == RC_W'(N - 1)) begin
            nxt_row = c_row_q + 1'b1;
            nxt_col = '0;
        end
    end

    always_comb begin
        nxt_data = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (nxt_row == RC_W'(r) && nxt_col == RC_W'(c))
                    nxt_data = acc_w[r*N+c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            c_valid_q  <= 1'b0;
            c_data_q   <= '0;
            c_row_q    <= '0;
            c_col_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (bus.in_last) begin
                            state_q    <= S_DRAIN;
                            in_ready_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                // Last product reaches PE(N-1,N-1) after 2N-2 cycles, +1 to accumulate.
                S_DRAIN: begin
                    if (cnt_q == CNT_W'(2 * N - 2)) begin
                        state_q   <= S_OUT;
                        c_valid_q <= 1'b1;
                        c_data_q  <= acc_w[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_hs) begin
                        if (last_elem) begin
                            state_q    <= S_IDLE;
                            c_valid_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                            c_data_q   <= '0;
                            c_row_q    <= '0;
                            c_col_q    <= '0;
                        end else begin
                            c_row_q  <= nxt_row;
                            c_col_q  <= nxt_col;
                            c_data_q <= nxt_data;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.c_valid  = c_valid_q;
    assign bus.c_data   = c_data_q;
    assign bus.c_row    = c_row_q;
    assign bus.c_col    = c_col_q;
    assign busy         = busy_q;

`ifdef SYSMM_DBG_C_EN
    assign dbg_c = acc_w;
`endif
endmodule

// File: tb/tb_systolic_mm_nxn.sv
module tb_systolic_mm_nxn;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_mm_nxn_if #(.N(2), .DATA_W(32), .ACC_W(32)) if2 ();
    systolic_mm_nxn_if #(.N(4), .DATA_W(32), .ACC_W(32)) if4 ();
    systolic_mm_nxn_if #(.N(1), .DATA_W(8),  .ACC_W(8))  if1 ();
    logic busy2, busy4, busy1;
`ifdef SYSMM_DBG_C_EN
    logic [4*32-1:0]  dbg2;
    logic [16*32-1:0] dbg4;
    logic [7:0]       dbg1;
`endif

    systolic_mm_nxn #(.N(2), .DATA_W(32), .ACC_W(32)) u2 (
        .clk(clk), .rst(rst), .bus(if2.slave), .busy(busy2)
`ifdef SYSMM_DBG_C_EN
        , .dbg_c(dbg2)
`endif
    );
    systolic_mm_nxn #(.N(4), .DATA_W(32), .ACC_W(32)) u4 (
        .clk(clk), .rst(rst), .bus(if4.slave), .busy(busy4)
`ifdef SYSMM_DBG_C_EN
        , .dbg_c(dbg4)
`endif
    );
    systolic_mm_nxn #(.N(1), .DATA_W(8), .ACC_W(8)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .busy(busy1)
`ifdef SYSMM_DBG_C_EN
        , .dbg_c(dbg1)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp2 [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
    logic [31:0] got_d [16];
    int got_r [16];
    int got_c [16];
    int got_n;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat2(input logic [31:0] a0, a1, b0, b1, input logic last);
        if2.a_col    = {a1, a0};
        if2.b_row    = {b1, b0};
        if2.in_last  = last;
        if2.in_valid = 1'b1;
        tick();
        if2.in_valid = 1'b0;
        if2.in_last  = 1'b0;
    endtask

    task automatic collect2(input int budget);
        got_n = 0;
        if2.c_ready = 1'b1;
        for (int t = 0; t < budget && got_n < 4; t++) begin
            if (if2.c_valid) begin
                got_d[got_n] = if2.c_data;
                got_r[got_n] = int'(if2.c_row);
                got_c[got_n] = int'(if2.c_col);
                got_n++;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", if2.in_ready); end
        checks++; if (if2.c_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %b want 0", if2.c_valid); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy2); end
        checks++; if (if2.c_data !== 32'd0) begin errors++; $display("FAIL reset_c_data: got %0d want 0", if2.c_data); end
        checks++; if (if2.c_row !== 1'b0 || if2.c_col !== 1'b0) begin errors++; $display("FAIL reset_rc: got %0d,%0d want 0,0", if2.c_row, if2.c_col); end
        checks++; if (if4.in_ready !== 1'b1 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_n4: got rdy=%b busy=%b want 1,0", if4.in_ready, busy4); end
        checks++; if (if1.c_valid !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_n1: got v=%b busy=%b want 0,0", if1.c_valid, busy1); end
    endtask

    task automatic test_basic;
        int lat;
        beat2(32'd1, 32'd3, 32'd5, 32'd6, 1'b0);
        checks++; if (busy2 !== 1'b1 || if2.in_ready !== 1'b1) begin errors++; $display("FAIL basic_load: got busy=%b rdy=%b want 1,1", busy2, if2.in_ready); end
        if2.a_col = {32'd4, 32'd2}; if2.b_row = {32'd8, 32'd7};
        if2.in_last = 1'b1; if2.in_valid = 1'b1;
        tick();
        // Keep offering a junk beat during DRAIN; it must be ignored.
        if2.in_last = 1'b0; if2.a_col = {32'd99, 32'd99}; if2.b_row = {32'd99, 32'd99};
        checks++; if (if2.in_ready !== 1'b0 || busy2 !== 1'b1) begin errors++; $display("FAIL basic_drain: got rdy=%b busy=%b want 0,1", if2.in_ready, busy2); end
        lat = 0;
        while (!if2.c_valid && lat < 20) begin tick(); lat++; end
        if2.in_valid = 1'b0;
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
        collect2(20);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got_n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_d[k] !== exp2[k] || got_r[k] !== k / 2 || got_c[k] !== k % 2) begin
                errors++;
                $display("FAIL basic_elem%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", k, got_d[k], got_r[k], got_c[k], exp2[k], k / 2, k % 2);
            end
        end
        checks++; if (busy2 !== 1'b0 || if2.in_ready !== 1'b1 || if2.c_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b rdy=%b v=%b want 0,1,0", busy2, if2.in_ready, if2.c_valid); end
    endtask

    task automatic test_bubbles;
        beat2(32'd1, 32'd3, 32'd5, 32'd6, 1'b0);
        tick(); tick(); tick();
        beat2(32'd2, 32'd4, 32'd7, 32'd8, 1'b1);
        collect2(30);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL bubbles_count: got %0d want 4", got_n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_d[k] !== exp2[k] || got_r[k] !== k / 2 || got_c[k] !== k % 2) begin
                errors++;
                $display("FAIL bubbles_elem%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", k, got_d[k], got_r[k], got_c[k], exp2[k], k / 2, k % 2);
            end
        end
    endtask

    task automatic test_backpressure;
        int t;
        if2.c_ready = 1'b0;
        beat2(32'd1, 32'd3, 32'd5, 32'd6, 1'b0);
        beat2(32'd2, 32'd4, 32'd7, 32'd8, 1'b1);
        t = 0;
        while (!if2.c_valid && t < 20) begin tick(); t++; end
        checks++; if (if2.c_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", if2.c_valid); end
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (if2.c_valid !== 1'b1 || if2.c_data !== 32'd19 || if2.c_row !== 1'b0 || if2.c_col !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b %0d@(%0d,%0d) want 1 19@(0,0)", s, if2.c_valid, if2.c_data, if2.c_row, if2.c_col);
            end
            tick();
        end
        collect2(20);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL stall_count: got %0d want 4", got_n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_d[k] !== exp2[k] || got_r[k] !== k / 2 || got_c[k] !== k % 2) begin
                errors++;
                $display("FAIL stall_elem%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", k, got_d[k], got_r[k], got_c[k], exp2[k], k / 2, k % 2);
            end
        end
    endtask

    task automatic test_n4_k1;
        int lat;
        int n;
        if4.a_col = {32'd4, 32'd3, 32'd2, 32'd1};
        if4.b_row = {32'd4, 32'd3, 32'd2, 32'd1};
        if4.in_last = 1'b1; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0; if4.in_last = 1'b0;
        checks++; if (busy4 !== 1'b1 || if4.in_ready !== 1'b0) begin errors++; $display("FAIL n4_drain: got busy=%b rdy=%b want 1,0", busy4, if4.in_ready); end
        lat = 0;
        while (!if4.c_valid && lat < 30) begin tick(); lat++; end
        checks++; if (lat !== 7) begin errors++; $display("FAIL n4_latency: got %0d want 7", lat); end
        if4.c_ready = 1'b1;
        n = 0;
        for (int t = 0; t < 40 && n < 16; t++) begin
            if (if4.c_valid) begin
                checks++;
                if (if4.c_data !== 32'((n / 4 + 1) * (n % 4 + 1)) || int'(if4.c_row) !== n / 4 || int'(if4.c_col) !== n % 4) begin
                    errors++;
                    $display("FAIL n4_elem%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", n, if4.c_data, if4.c_row, if4.c_col, (n / 4 + 1) * (n % 4 + 1), n / 4, n % 4);
                end
                n++;
            end
            tick();
        end
        checks++; if (n !== 16 || busy4 !== 1'b0) begin errors++; $display("FAIL n4_count: got %0d busy=%b want 16 busy=0", n, busy4); end
    endtask

    task automatic test_wrap;
        int lat;
        if1.c_ready = 1'b0;
        if1.a_col = 8'd200; if1.b_row = 8'd2; if1.in_valid = 1'b1;
        tick();
        if1.a_col = 8'd100; if1.b_row = 8'd1; if1.in_last = 1'b1;
        tick();
        if1.in_valid = 1'b0; if1.in_last = 1'b0;
        lat = 0;
        while (!if1.c_valid && lat < 10) begin tick(); lat++; end
        checks++; if (lat !== 1) begin errors++; $display("FAIL wrap_latency: got %0d want 1", lat); end
        checks++; if (if1.c_data !== 8'd244 || if1.c_row !== 1'b0 || if1.c_col !== 1'b0) begin errors++; $display("FAIL wrap_data: got %0d@(%0d,%0d) want 244@(0,0)", if1.c_data, if1.c_row, if1.c_col); end
        if1.c_ready = 1'b1;
        tick();
        checks++; if (if1.c_valid !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL wrap_done: got v=%b busy=%b want 0,0", if1.c_valid, busy1); end
    endtask

    task automatic test_reset_mid;
        beat2(32'd1, 32'd3, 32'd5, 32'd6, 1'b0);
        beat2(32'd2, 32'd4, 32'd7, 32'd8, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (if2.in_ready !== 1'b1 || busy2 !== 1'b0 || if2.c_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state: got rdy=%b busy=%b v=%b want 1,0,0", if2.in_ready, busy2, if2.c_valid); end
        beat2(32'd1, 32'd3, 32'd5, 32'd6, 1'b0);
        beat2(32'd2, 32'd4, 32'd7, 32'd8, 1'b1);
        collect2(20);
        checks++; if (got_n !== 4) begin errors++; $display("FAIL rstmid_count: got %0d want 4", got_n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_d[k] !== exp2[k] || got_r[k] !== k / 2 || got_c[k] !== k % 2) begin
                errors++;
                $display("FAIL rstmid_elem%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", k, got_d[k], got_r[k], got_c[k], exp2[k], k / 2, k % 2);
            end
        end
    endtask

    initial begin
        if2.in_valid = 1'b0; if2.in_last = 1'b0; if2.a_col = '0; if2.b_row = '0; if2.c_ready = 1'b1;
        if4.in_valid = 1'b0; if4.in_last = 1'b0; if4.a_col = '0; if4.b_row = '0; if4.c_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_last = 1'b0; if1.a_col = '0; if1.b_row = '0; if1.c_ready = 1'b1;
        test_reset();
        test_basic();
        test_bubbles();
        test_backpressure();
        test_n4_k1();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
